mem_access_master: RTL and testbench

//  Initiator side of the Memory ren/wen/addr/din/dout port. Accepts single or burst word requests

---
 rtl/mem_access_master.sv | 198 +++++++++++++++++++
 tb/tb_mem_access_master.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_master.sv
// mem_access_master
//   Initiator side of the Memory ren/wen/addr/din/dout port. It takes single-word
//   or burst requests over a valid/ready handshake and turns each word into one
//   Memory cycle. Write data arrives over its own handshake, and read data is
//   returned as one pulse per word.
//   Every output is driven from a flop. Each Memory cycle is built so that
//   mem_ren and mem_wen are never high together, and so that mem_addr and
//   mem_din are held steady while a strobe is high. A write beat also keeps
//   addr and din for one extra cycle after its strobe.
//
// Ports
//   clock, reset        single clock; synchronous active-high reset
//   req_valid/ready     burst request handshake (req_ready high only when idle)
//   req_write/addr/len  burst direction, start word address, word count (0 -> 1)
//   wdata_valid/ready   per-beat write data handshake
//   wdata               write data word
//   rdata_valid/rdata   read word pulse; rdata holds until the next read word
//   done, err           end-of-burst pulse; err flags a beat address above 10 bits
//   busy                high whenever a burst is in progress
//   mem_*               Memory port (ren, wen, addr, din out; dout in)
module mem_access_master #(
  parameter int          LEN_W     = 4,
  parameter logic [31:0] ADDR_STEP = 32'd1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [31:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic             wdata_valid,
  output logic             wdata_ready,
  input  logic [31:0]      wdata,
  output logic             rdata_valid,
  output logic [31:0]      rdata,
  output logic             done,
  output logic             err,
  output logic             busy,
  output logic             mem_ren,
  output logic             mem_wen,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_din,
  input  logic [31:0]      mem_dout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             write_q, write_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      din_q, din_d;
  logic [LEN_W-1:0] beats_q, beats_d;
  logic             err_q, err_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rdata_valid_q, rdata_valid_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             req_ready_q, req_ready_d;
  logic             wdata_ready_q, wdata_ready_d;
  logic             ren_q, ren_d;
  logic             wen_q, wen_d;

  logic             beat_end;
  logic [LEN_W-1:0] beats_left;
  logic [31:0]      next_addr;

  assign beats_left = beats_q - LEN_W'(1);
  assign next_addr  = addr_q + ADDR_STEP;

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    addr_d   = addr_q;
    din_d    = din_q;
    beats_d  = beats_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    beat_end = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          write_d = req_write;
          addr_d  = req_addr;
          beats_d = (req_len == '0) ? LEN_W'(1) : req_len;
          err_d   = |req_addr[31:10];
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (!write_q) begin
          state_d = S_STROBE;
        end else if (wdata_valid && wdata_ready_q) begin
          din_d   = wdata;
          state_d = S_STROBE;
        end
      end
      S_STROBE: begin
        if (write_q) begin
          state_d = S_HOLD;
        end else begin
          // Memory read is combinational: capture dout while ren is high.
          rdata_d  = mem_dout;
          beat_end = 1'b1;
        end
      end
      S_HOLD: begin
        beat_end = 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The address only moves on the edge out of a strobe-free cycle or out of
    // a read strobe. The new value therefore first appears in SETUP, where
    // both strobes are low.
    if (beat_end) begin
      beats_d = beats_left;
      if (beats_left != '0) begin
        addr_d  = next_addr;
        err_d   = err_q | (|next_addr[31:10]);
        state_d = S_SETUP;
      end else begin
        state_d = S_DONE;
      end
    end
  end

  // Registered outputs are decoded from the state being entered.
  always_comb begin
    req_ready_d   = (state_d == S_IDLE);
    busy_d        = (state_d != S_IDLE);
    wdata_ready_d = (state_d == S_SETUP) && write_d;
    ren_d         = (state_d == S_STROBE) && !write_d;
    wen_d         = (state_d == S_STROBE) && write_d;
    done_d        = (state_d == S_DONE);
    rdata_valid_d = (state_q == S_STROBE) && !write_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      write_q       <= 1'b0;
      addr_q        <= '0;
      din_q         <= '0;
      beats_q       <= '0;
      err_q         <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      req_ready_q   <= 1'b1;
      wdata_ready_q <= 1'b0;
      ren_q         <= 1'b0;
      wen_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      addr_q        <= addr_d;
      din_q         <= din_d;
      beats_q       <= beats_d;
      err_q         <= err_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      req_ready_q   <= req_ready_d;
      wdata_ready_q <= wdata_ready_d;
      ren_q         <= ren_d;
      wen_q         <= wen_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign wdata_ready = wdata_ready_q;
  assign rdata_valid = rdata_valid_q;
  assign rdata       = rdata_q;
  assign done        = done_q;
  assign err         = err_q;
  assign busy        = busy_q;
  assign mem_ren     = ren_q;
  assign mem_wen     = wen_q;
  assign mem_addr    = addr_q;
  assign mem_din     = din_q;

endmodule

// File: tb/tb_mem_access_master.sv
// Testbench for mem_access_master. It includes a behavioural Memory and a
// reference word array, and runs table-driven bursts, a mid-burst reset and
// random bursts. It also keeps a bus monitor active on every cycle.
module tb_mem_access_master;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_len = '0;
  logic        wdata_valid = 1'b0;
  logic        wdata_ready;
  logic [31:0] wdata = '0;
  logic        rdata_valid;
  logic [31:0] rdata;
  logic        done;
  logic        err;
  logic        busy;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  mem_access_master #(.LEN_W(4), .ADDR_STEP(32'd1)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata(rdata), .done(done), .err(err), .busy(busy),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  // Memory block: 1024 words, combinational read, write on clock edge
  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  assign mem_dout = mem[mem_addr[9:0]];
  always @(posedge clock) if (mem_wen) mem[mem_addr[9:0]] <= mem_din;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Bus monitor: strobes exclusive, addr steady under a strobe, addr/din held after a write
  logic        prev_wen = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_din = '0;
  always @(negedge clock) begin
    if (!reset) begin
      chk("ren_wen_exclusive", 32'(mem_ren & mem_wen), 32'd0);
      if (mem_ren | mem_wen) chk("addr_stable_under_strobe", mem_addr, prev_addr);
      if (prev_wen) begin
        chk("addr_hold_after_wen", mem_addr, prev_addr);
        chk("din_hold_after_wen", mem_din, prev_din);
      end
    end
    prev_wen  = mem_wen & ~reset;
    prev_addr = mem_addr;
    prev_din  = mem_din;
  end

  int burst_no = 0;

  // One burst, checked against the reference word array and the timing rules
  task automatic run_burst(input bit wr, input logic [31:0] a, input int len,
                           input logic [31:0] base, input int stall_beat,
                           input int stall_n, input bit hold, output bit got_err);
    int n, cyc, nwen, nren, nrv, widx, stall_left, exp_done;
    bit got_done, exp_err;
    logic [31:0] ai;
    n = (len == 0) ? 1 : len;
    exp_err = 1'b0;
    for (int i = 0; i < n; i++) begin
      ai = a + 32'(i);
      if (ai[31:10] != '0) exp_err = 1'b1;
    end
    if (wr) exp_done = 3 * n + 1 + ((stall_beat >= 0 && stall_beat < n) ? stall_n : 0);
    else    exp_done = 2 * n + 1;
    cyc = 0; nwen = 0; nren = 0; nrv = 0; widx = 0; stall_left = stall_n;
    got_done = 1'b0; got_err = 1'b0;

    @(negedge clock);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    chk("busy_idle", 32'(busy), 32'd0);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_len = 4'(len);
    @(posedge clock);
    while (!got_done && cyc < 400) begin
      @(negedge clock);
      cyc++;
      if (!hold) req_valid = 1'b0;
      else if (!done) chk("req_ready_while_busy", 32'(req_ready), 32'd0);
      if (mem_wen) begin
        ai = a + 32'(nwen);
        chk("wen_addr", mem_addr, ai);
        chk("wen_din", mem_din, base + 32'(nwen));
        nwen++;
      end
      if (mem_ren) begin
        chk("ren_addr", mem_addr, a + 32'(nren));
        nren++;
      end
      if (rdata_valid) begin
        ai = a + 32'(nrv);
        chk("rdata", rdata, ref_mem[ai[9:0]]);
        chk("rdata_cycle", 32'(cyc), 32'(3 + 2 * nrv));
        nrv++;
      end
      if (done) begin
        got_done = 1'b1;
        got_err = err;
        req_valid = 1'b0;
        wdata_valid = 1'b0;
      end else if (wdata_ready) begin
        if (widx == stall_beat && stall_left > 0) begin
          wdata_valid = 1'b0;
          stall_left--;
        end else begin
          wdata_valid = 1'b1;
          wdata = base + 32'(widx);
          widx++;
        end
      end else begin
        // Noise outside the write-data window must be ignored.
        wdata_valid = 1'($urandom_range(0, 1));
        wdata = $urandom;
      end
    end
    chk("done_seen", 32'(got_done), 32'd1);
    chk("done_cycle", 32'(cyc), 32'(exp_done));
    chk("err_with_done", 32'(got_err), 32'(exp_err));
    chk("wen_pulses", 32'(nwen), wr ? 32'(n) : 32'd0);
    chk("ren_pulses", 32'(nren), wr ? 32'd0 : 32'(n));
    chk("rdata_pulses", 32'(nrv), wr ? 32'd0 : 32'(n));
    if (wr) begin
      for (int i = 0; i < n; i++) begin
        ai = a + 32'(i);
        ref_mem[ai[9:0]] = base + 32'(i);
      end
      for (int i = 0; i < n; i++) begin
        ai = a + 32'(i);
        chk("mem_contents", mem[ai[9:0]], ref_mem[ai[9:0]]);
      end
    end
    $display("burst %0d %s addr=0x%08h len=%0d done_cycle=%0d err=%0d",
             burst_no, wr ? "write" : "read", a, len, cyc, got_err);
    burst_no++;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    int          len;
    logic [31:0] base;
    int          stall_beat;
    int          stall_n;
    bit          hold;
    bit          exp_err;
  } vec_t;

  vec_t tbl[10];

  initial begin
    bit          e;
    int          widx, nwen, guard;
    logic [31:0] ra;

    for (int i = 0; i < 1024; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end

    //           wr    addr            len base           stall  n  hold exp_err
    tbl[0] = '{1'b1, 32'h0000_0005, 1, 32'hDEAD_BEEF, -1, 0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 32'h0000_0005, 1, 32'h0,         -1, 0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 32'h0000_0010, 4, 32'h1,          2, 2, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 32'h0000_0010, 4, 32'h0,         -1, 0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 32'h0000_0007, 0, 32'h0,         -1, 0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 32'h0000_03FF, 2, 32'hA0,        -1, 0, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 32'h0000_0000, 1, 32'h0,         -1, 0, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 32'h0000_03FF, 2, 32'h0,         -1, 0, 1'b0, 1'b1};
    tbl[8] = '{1'b1, 32'hFFFF_FFFF, 2, 32'h77,         0, 3, 1'b0, 1'b1};
    tbl[9] = '{1'b0, 32'h0000_2000, 3, 32'h0,         -1, 0, 1'b0, 1'b1};

    // Reset values
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wdata_ready", 32'(wdata_ready), 32'd0);
    chk("rst_mem_ren", 32'(mem_ren), 32'd0);
    chk("rst_mem_wen", 32'(mem_wen), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_din", mem_din, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rdata_valid", 32'(rdata_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // Table-driven bursts
    for (int t = 0; t < 10; t++) begin
      run_burst(tbl[t].wr, tbl[t].addr, tbl[t].len, tbl[t].base,
                tbl[t].stall_beat, tbl[t].stall_n, tbl[t].hold, e);
      chk("table_err", 32'(e), 32'(tbl[t].exp_err));
    end

    // Reset during the strobe of beat 2 of a 4-beat write
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_len = 4'd4;
    @(posedge clock);
    widx = 0; nwen = 0; guard = 0;
    while (nwen < 2 && guard < 100) begin
      @(negedge clock);
      guard++;
      req_valid = 1'b0;
      if (mem_wen) nwen++;
      if (nwen == 2) begin
        reset = 1'b1;
        wdata_valid = 1'b0;
      end else if (wdata_ready) begin
        wdata_valid = 1'b1;
        wdata = 32'h50 + 32'(widx);
        widx++;
      end else begin
        wdata_valid = 1'b0;
      end
    end
    chk("reset_test_reached_beat2", 32'(nwen), 32'd2);
    @(negedge clock);
    chk("midrst_mem_wen", 32'(mem_wen), 32'd0);
    chk("midrst_mem_ren", 32'(mem_ren), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_rdata_valid", 32'(rdata_valid), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    ref_mem[32'h20] = 32'h50;
    ref_mem[32'h21] = 32'h51;
    for (int i = 0; i < 4; i++) chk("midrst_mem", mem[32'h20 + i], ref_mem[32'h20 + i]);
    $display("burst %0d write addr=0x00000020 len=4 interrupted by reset after beat 2", burst_no);
    burst_no++;
    run_burst(1'b0, 32'h20, 4, 32'h0, -1, 0, 1'b0, e);

    // Random bursts against the reference array
    for (int r = 0; r < 25; r++) begin
      ra = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 1023));
      run_burst(1'($urandom_range(0, 1)), ra, $urandom_range(0, 6), $urandom,
                $urandom_range(0, 1) ? $urandom_range(0, 5) : -1,
                $urandom_range(0, 3), 1'($urandom_range(0, 1)), e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
